// File: rtl/mult8x8_seq_ctrl_if.sv
// Handshake and data bundle for the sequential 8x8 multiplier controller.
//   start    : request a multiply (requester -> multiplier)
//   dataa    : operand A, 8 bits (requester -> multiplier)
//   datab    : operand B, 8 bits (requester -> multiplier)
//   sel_a    : nibble select for the A operand mux (multiplier -> requester)
//   sel_b    : nibble select for the B operand mux (multiplier -> requester)
//   shift    : partial-product shift code, 0:<<0 1:<<4 2:<<8 (multiplier -> requester)
//   busy     : multiply in progress (multiplier -> requester)
//   done     : product valid (multiplier -> requester)
//   product  : 16-bit accumulated result (multiplier -> requester)
interface mult8x8_seq_ctrl_if;
    logic        start;
    logic [7:0]  dataa;
    logic [7:0]  datab;
    logic        sel_a;
    logic        sel_b;
    logic [1:0]  shift;
    logic        busy;
    logic        done;
    logic [15:0] product;

    modport master (
        output start, dataa, datab,
        input  sel_a, sel_b, shift, busy, done, product
    );

    modport slave (
        input  start, dataa, datab,
        output sel_a, sel_b, shift, busy, done, product
    );
endinterface

// File: rtl/mult8x8_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier built from four 4x4 partial products.
// Latches the operands on start, then spends four CALC cycles stepping the
// nibble selects through {lo,lo}, {hi,lo}, {lo,hi}, {hi,hi}, accumulating
// each shifted partial product into a 16-bit product.
// Ports:
//   clk      : system clock, rising edge
//   reset_a  : asynchronous reset, active-high
//   bus      : slave side of mult8x8_seq_ctrl_if (start/operands in,
//              selects/shift/busy/done/product out)
// Parameters:
//   STICKY_DONE : 1 = done held until the next start; 0 = one-cycle done pulse
module mult8x8_seq_ctrl #(
    parameter bit STICKY_DONE = 1'b1
) (
    input logic               clk,
    input logic               reset_a,
    mult8x8_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  opa_q, opb_q;
    logic [15:0] prod_q, prod_d;
    logic        load;

    logic        calc;
    logic        sel_a, sel_b;
    logic [1:0]  shift;
    logic [3:0]  nib_a, nib_b;
    logic [7:0]  partial;
    logic [15:0] shifted;

    // Select/shift decode of the step counter; forced to zero outside CALC.
    always_comb begin
        calc  = (state_q == StCalc);
        sel_a = calc & cnt_q[0];
        sel_b = calc & cnt_q[1];
        shift = 2'd0;
        if (calc) begin
            case (cnt_q)
                2'd0:    shift = 2'd0;
                2'd1:    shift = 2'd1;
                2'd2:    shift = 2'd1;
                default: shift = 2'd2;
            endcase
        end
    end

    // Partial product of the selected nibbles, aligned by the shift code.
    always_comb begin
        nib_a   = sel_a ? opa_q[7:4] : opa_q[3:0];
        nib_b   = sel_b ? opb_q[7:4] : opb_q[3:0];
        partial = nib_a * nib_b;
        case (shift)
            2'd0:    shifted = {8'h00, partial};
            2'd1:    shifted = {4'h0, partial, 4'h0};
            2'd2:    shifted = {partial, 8'h00};
            default: shifted = 16'h0000;
        endcase
    end

    // Next-state logic. A start in DONE behaves exactly like one in IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        load    = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    load    = 1'b1;
                    prod_d  = 16'h0000;
                    cnt_d   = 2'd0;
                    state_d = StCalc;
                end else if (state_q == StDone && !STICKY_DONE) begin
                    state_d = StIdle;
                end
            end
            StCalc: begin
                // Maximum sum is 0xFE01, so 16 bits cannot overflow.
                prod_d = prod_q + shifted;
                cnt_d  = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
            opa_q   <= 8'h00;
            opb_q   <= 8'h00;
            prod_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            if (load) begin
                opa_q <= bus.dataa;
                opb_q <= bus.datab;
            end
        end
    end

    assign bus.sel_a   = sel_a;
    assign bus.sel_b   = sel_b;
    assign bus.shift   = shift;
    assign bus.busy    = calc;
    assign bus.done    = (state_q == StDone);
    assign bus.product = prod_q;

endmodule

// File: tb/tb_mult8x8_seq_ctrl.sv
// Self-checking bench for mult8x8_seq_ctrl: a sticky-done instance driven by a
// vector table plus hand-written corner sequences, and a pulse-done instance.
module tb_mult8x8_seq_ctrl;

    logic clk;
    logic reset_a;

    mult8x8_seq_ctrl_if bus1 ();
    mult8x8_seq_ctrl_if bus2 ();

    mult8x8_seq_ctrl #(.STICKY_DONE(1'b1)) dut_sticky (
        .clk     (clk),
        .reset_a (reset_a),
        .bus     (bus1)
    );

    mult8x8_seq_ctrl #(.STICKY_DONE(1'b0)) dut_pulse (
        .clk     (clk),
        .reset_a (reset_a),
        .bus     (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp_product;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected select/shift sequence over the four CALC cycles.
    logic       exp_sa [4];
    logic       exp_sb [4];
    logic [1:0] exp_sh [4];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full operation on the sticky instance; called #1 after a clock edge.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp, input string tag);
        bus1.dataa = a;
        bus1.datab = b;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        check({tag, " product cleared"}, bus1.product, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s busy c%0d", tag, k), {15'd0, bus1.busy}, 16'd1);
            check($sformatf("%s done c%0d", tag, k), {15'd0, bus1.done}, 16'd0);
            check($sformatf("%s sel_a c%0d", tag, k), {15'd0, bus1.sel_a}, {15'd0, exp_sa[k]});
            check($sformatf("%s sel_b c%0d", tag, k), {15'd0, bus1.sel_b}, {15'd0, exp_sb[k]});
            check($sformatf("%s shift c%0d", tag, k), {14'd0, bus1.shift}, {14'd0, exp_sh[k]});
            tick();
        end
        check({tag, " done"}, {15'd0, bus1.done}, 16'd1);
        check({tag, " busy end"}, {15'd0, bus1.busy}, 16'd0);
        check({tag, " product"}, bus1.product, exp);
        check({tag, " sel/shift idle"}, {12'd0, bus1.sel_a, bus1.sel_b, bus1.shift}, 16'd0);
        tick();
        check({tag, " done held"}, {15'd0, bus1.done}, 16'd1);
        check({tag, " product held"}, bus1.product, exp);
    endtask

    vec_t vecs [6];

    initial begin
        exp_sa[0] = 1'b0; exp_sb[0] = 1'b0; exp_sh[0] = 2'd0;
        exp_sa[1] = 1'b1; exp_sb[1] = 1'b0; exp_sh[1] = 2'd1;
        exp_sa[2] = 1'b0; exp_sb[2] = 1'b1; exp_sh[2] = 2'd1;
        exp_sa[3] = 1'b1; exp_sb[3] = 1'b1; exp_sh[3] = 2'd2;

        vecs[0] = '{8'h12, 8'h34, 16'h03A8};
        vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
        vecs[2] = '{8'h00, 8'hA5, 16'h0000};
        vecs[3] = '{8'h0F, 8'hF0, 16'h0E10};
        vecs[4] = '{8'h80, 8'h02, 16'h0100};
        vecs[5] = '{8'hAB, 8'hCD, 16'h88EF};

        reset_a    = 1'b1;
        bus1.start = 1'b0;
        bus1.dataa = 8'h00;
        bus1.datab = 8'h00;
        bus2.start = 1'b0;
        bus2.dataa = 8'h00;
        bus2.datab = 8'h00;
        tick();
        tick();
        check("reset product", bus1.product, 16'h0000);
        check("reset busy/done", {14'd0, bus1.busy, bus1.done}, 16'd0);
        check("reset sel/shift", {12'd0, bus1.sel_a, bus1.sel_b, bus1.shift}, 16'd0);
        check("reset pulse dut", {bus2.product[13:0], bus2.busy, bus2.done}, 16'd0);
        reset_a = 1'b0;
        tick();
        check("idle no start", {14'd0, bus1.busy, bus1.done}, 16'd0);

        // Table-driven vectors; each restart from DONE also checks done falls.
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp_product, $sformatf("vec%0d", i));
        end

        // Start during CALC must be ignored, including new operand values.
        bus1.dataa = 8'h12;
        bus1.datab = 8'h34;
        bus1.start = 1'b1;
        tick();                     // E0
        bus1.start = 1'b0;
        tick();                     // E1
        tick();                     // E2
        bus1.dataa = 8'hFF;
        bus1.datab = 8'hFF;
        bus1.start = 1'b1;
        tick();                     // E3, start ignored
        bus1.start = 1'b0;
        check("ign busy E3", {15'd0, bus1.busy}, 16'd1);
        check("ign sel E3", {14'd0, bus1.sel_a, bus1.sel_b}, 16'd3);
        tick();                     // E4
        check("ign done", {15'd0, bus1.done}, 16'd1);
        check("ign product", bus1.product, 16'h03A8);
        tick();
        check("ign product held", bus1.product, 16'h03A8);

        // Restart from DONE holding 0x03A8.
        run_op(8'h0F, 8'hF0, 16'h0E10, "restart");

        // Asynchronous reset between E2 and E3 aborts immediately.
        bus1.dataa = 8'hFF;
        bus1.datab = 8'hFF;
        bus1.start = 1'b1;
        tick();                     // E0
        bus1.start = 1'b0;
        tick();                     // E1
        tick();                     // E2
        check("pre-abort product nonzero", {15'd0, (bus1.product != 16'h0000)}, 16'd1);
        #3;
        reset_a = 1'b1;
        #1;
        check("abort product", bus1.product, 16'h0000);
        check("abort busy/done", {14'd0, bus1.busy, bus1.done}, 16'd0);
        check("abort sel/shift", {12'd0, bus1.sel_a, bus1.sel_b, bus1.shift}, 16'd0);
        tick();
        reset_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("post-abort idle c%0d", k),
                  {bus1.product[13:0], bus1.busy, bus1.done}, 16'd0);
        end

        // Pulse-done instance: done for one cycle only, product retained.
        bus2.dataa = 8'h12;
        bus2.datab = 8'h34;
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("pulse busy c%0d", k), {14'd0, bus2.busy, bus2.done}, 16'd2);
            tick();
        end
        check("pulse done", {14'd0, bus2.busy, bus2.done}, 16'd1);
        check("pulse product", bus2.product, 16'h03A8);
        tick();
        check("pulse done drops", {14'd0, bus2.busy, bus2.done}, 16'd0);
        check("pulse product kept", bus2.product, 16'h03A8);
        tick();
        check("pulse idle product", bus2.product, 16'h03A8);
        check("pulse idle flags", {14'd0, bus2.busy, bus2.done}, 16'd0);
        bus2.dataa = 8'h01;
        bus2.datab = 8'h01;
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        check("pulse restart clears", bus2.product, 16'h0000);
        check("pulse restart busy", {15'd0, bus2.busy}, 16'd1);
        repeat (4) tick();
        check("pulse restart product", bus2.product, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult8x8_seq_ctrl.md
Name: mult8x8_seq_ctrl

Overview:
Control-and-datapath stage that drives the nibble-select lines of the two 4-bit operand muxes and produces the 16-bit product. Latches two 8-bit operands on start. Over four cycles it steps the selects through {lo,lo}, {hi,lo}, {lo,hi}, {hi,hi}, forms each 4x4 partial product, shifts it and accumulates it. Handshake is start/done, feeding the product/display logic downstream.

Parameters:
STICKY_DONE, 1, 1 = done and product held in DONE until next start; 0 = done is a one-cycle pulse, then return to IDLE (product still held)

Ports:
clk  input  1  system clock, rising edge
reset_a  input  1  asynchronous reset, active-high
start  input  1  request multiply; sampled in IDLE and DONE only
dataa  input  8  operand A
datab  input  8  operand B
sel_a  output  1  nibble select for A mux (0 = dataa[3:0], 1 = dataa[7:4])
sel_b  output  1  nibble select for B mux (0 = datab[3:0], 1 = datab[7:4])
shift  output  2  current partial-product shift code (0 = <<0, 1 = <<4, 2 = <<8)
busy  output  1  high in CALC
done  output  1  product valid
product  output  16  accumulated result

Behaviour:
- Reset (async, reset_a=1): state=IDLE, cnt=0, operand regs=0, product=0, sel_a=0, sel_b=0, shift=0, busy=0, done=0. Reset asserted mid-CALC aborts immediately. After release, the block waits in IDLE for a new start.
- States: IDLE, CALC, DONE. cnt is 2 bits, valid in CALC.
- IDLE, start=1 at edge E0: latch dataa/datab into internal regs, product<=0, cnt<=0, state<=CALC. Operand inputs are not sampled again until the next start.
- CALC: sel/shift are combinational decodes of cnt.
  - cnt0: sel_a=0, sel_b=0, shift=0
  - cnt1: sel_a=1, sel_b=0, shift=1
  - cnt2: sel_a=0, sel_b=1, shift=1
  - cnt3: sel_a=1, sel_b=1, shift=2
- Outside CALC, sel_a, sel_b and shift are all 0.
- Partial product = selected A nibble x selected B nibble: 8-bit unsigned, zero-extended to 16, shifted per shift code.
- Each edge in CALC: product <= product + shifted partial (16-bit, cannot overflow since max is 0xFE01); cnt <= cnt+1.
- At E4 (cnt3 accumulate edge): state<=DONE.
  - STICKY_DONE=1: done=1 from E4 until the next start edge.
  - STICKY_DONE=0: done=1 for exactly the cycle after E4, then state<=IDLE.
- Latency: product valid and done=1 exactly 4 clocks after the start-sampling edge.
- busy=1 exactly in cycles E0..E4 (state CALC); done and busy are never both 1.
- start while in CALC: ignored; the operation continues unchanged.
- start in DONE (or during the done pulse for STICKY_DONE=0): treated as IDLE start. Same-edge restart: operands latched, product<=0, done<=0, state<=CALC.
- product holds its last value in IDLE/DONE until the next start clears it.
- Unsigned arithmetic only.

Test Plan:
- Reset then dataa=0x12, datab=0x34, start 1 cycle -> busy 4 cycles. Sel sequence (a,b)=(0,0),(1,0),(0,1),(1,1) with shift 0,1,1,2. done=1 at E4 with product=0x03A8, held while start=0.
- dataa=0xFF, datab=0xFF -> product=0xFE01, no overflow. dataa=0x00, datab=0xA5 -> product=0x0000, done at E4.
- Start 0x12*0x34, then at E2 change dataa/datab to 0xFF and pulse start -> ignored. Result 0x03A8 at E4, busy never drops early.
- While in DONE with 0x03A8, start with dataa=0x0F, datab=0xF0 -> done falls on that edge. 4 cycles later product=0x0E10, done=1.
- Start 0xFF*0xFF, assert reset_a asynchronously between E2 and E3 -> product, done, busy, sel_a, sel_b, shift all 0 immediately. After release, outputs stay 0 with no start.
- STICKY_DONE=0, 0x12*0x34 -> done high exactly one cycle, then IDLE. product stays 0x03A8 until the next start.
